adc_seq: RTL and testbench

Command sequencer for the dual-chip ADC SPI engine (16-bit command out, 32-bit {chip0,chip1} result in, fs/fd_prd handshake). It runs the power-up configuration sequence: register writes, CALIBRATE and dummy commands. After that, each start pulse runs one sampling frame of CONVERT commands, plus pipeline-flush dummies. Returned words are re-aligned to channel index before being passed downstream.

---
 rtl/adc_pkg.sv | 48 ++++
 rtl/adc_seq_if.sv | 10 +
 rtl/adc_cmd_rom.sv | 27 ++
 rtl/adc_seq.sv | 142 ++++++++++++++
 tb/tb_adc_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the dual-chip ADC command sequencer: command
// encodings, the power-up register table and the FSM state codes.
package adc_pkg;

  localparam logic [1:0]  OP_CONVERT    = 2'b00;
  localparam logic [1:0]  OP_WRITE      = 2'b10;
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_DUMMY     = 16'hE800;  // READ register 40

  localparam int INIT_REGS = 8;

  // 8-bit state codes keep the encoding aligned with the SPI engine's FSM.
  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_LOAD = 8'h01;
  localparam logic [7:0] ST_REQ  = 8'h02;
  localparam logic [7:0] ST_RELS = 8'h03;
  localparam logic [7:0] ST_NEXT = 8'h04;

  typedef enum logic {
    MODE_CFG = 1'b0,
    MODE_FRM = 1'b1
  } mode_t;

  function automatic logic [15:0] cmd_write(input logic [5:0] r, input logic [7:0] v);
    return {OP_WRITE, r, v};
  endfunction

  function automatic logic [15:0] cmd_convert(input logic [5:0] c);
    return {OP_CONVERT, c, 8'h00};
  endfunction

  // Power-up values for configuration registers 0..7.
  function automatic logic [7:0] init_val(input logic [2:0] r);
    logic [7:0] v;
    case (r)
      3'd0:    v = 8'h03;
      3'd1:    v = 8'h10;
      3'd2:    v = 8'h00;
      3'd3:    v = 8'h44;
      3'd4:    v = 8'h0F;
      3'd5:    v = 8'hA5;
      3'd6:    v = 8'h20;
      default: v = 8'h81;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adc_seq_if.sv
// Handshake between the command sequencer (master) and the SPI engine (slave).
interface adc_seq_if;
  logic        fs;
  logic        fd_prd;
  logic [15:0] chip_txd;
  logic [31:0] chip_rxd;

  modport master (output fs, chip_txd, input fd_prd, chip_rxd);
  modport slave  (input fs, chip_txd, output fd_prd, chip_rxd);
endinterface

// File: rtl/adc_cmd_rom.sv
// Command table lookup: (list, index) -> 16-bit ADC command.
module adc_cmd_rom
  import adc_pkg::*;
#(
  parameter int NUM_CH = 32
) (
  input  mode_t       mode,
  input  logic [6:0]  txn,
  output logic [15:0] cmd
);

  localparam logic [6:0] REGS_T = 7'(INIT_REGS);
  localparam logic [6:0] NCH_T  = 7'(NUM_CH);

  // NOTE: a default assignment before any branch keeps this purely
  // combinational; a path that leaves cmd unassigned would infer a latch.
  always_comb begin
    cmd = CMD_DUMMY;
    if (mode == MODE_CFG) begin
      if (txn < REGS_T)       cmd = cmd_write(txn[5:0], init_val(txn[2:0]));
      else if (txn == REGS_T) cmd = CMD_CALIBRATE;
    end else if (txn < NCH_T) begin
      cmd = cmd_convert(txn[5:0]);
    end
  end

endmodule

// File: rtl/adc_seq.sv
// ADC command sequencer: power-up configuration list and per-start sampling
// frames over the fs/fd_prd handshake, with results re-aligned to channel.
module adc_seq
  import adc_pkg::*;
#(
  parameter int NUM_CH    = 32,
  parameter int PIPE      = 2,
  parameter int CAL_DUMMY = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        start,
  adc_seq_if.master   spi,
  output logic [31:0] data_out,
  output logic        data_vld,
  output logic [5:0]  ch_idx,
  output logic        frame_done,
  output logic        cfg_done,
  output logic        busy,
  output logic        ovr
);

  localparam logic [6:0] CFG_LAST = 7'(INIT_REGS + CAL_DUMMY);
  localparam logic [6:0] FRM_LAST = 7'(NUM_CH + PIPE - 1);
  localparam logic [6:0] PIPE_T   = 7'(PIPE);

  logic [7:0]  state;
  mode_t       mode;
  logic [6:0]  txn;
  logic        init_pend;

  logic        init_go;
  logic        start_go;
  logic        last_txn;
  mode_t       rom_mode;
  logic [6:0]  rom_txn;
  logic [15:0] rom_cmd;

  assign init_go  = init | init_pend;
  assign start_go = start & cfg_done;
  assign last_txn = (mode == MODE_CFG) ? (txn == CFG_LAST) : (txn == FRM_LAST);
  assign busy     = (state != ST_IDLE);

  // The command is fetched on the way into LOAD, so chip_txd is stable for
  // the whole LOAD cycle before fs rises.
  assign rom_mode = (state == ST_IDLE) ? (init_go ? MODE_CFG : MODE_FRM) : mode;
  assign rom_txn  = (state == ST_IDLE) ? 7'd0 : txn + 7'd1;

  adc_cmd_rom #(.NUM_CH(NUM_CH)) u_rom (
    .mode (rom_mode),
    .txn  (rom_txn),
    .cmd  (rom_cmd)
  );

  // NOTE: every register here uses <= so all updates in a cycle see the
  // pre-edge values of each other; blocking assignments would order them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      mode         <= MODE_CFG;
      txn          <= '0;
      init_pend    <= 1'b0;
      spi.fs       <= 1'b0;
      spi.chip_txd <= '0;
      data_out     <= '0;
      data_vld     <= 1'b0;
      ch_idx       <= '0;
      frame_done   <= 1'b0;
      cfg_done     <= 1'b0;
      ovr          <= 1'b0;
    end else begin
      data_vld   <= 1'b0;
      frame_done <= 1'b0;

      if (busy && init)  init_pend <= 1'b1;
      if (busy && start) ovr       <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (init_go) begin
            mode         <= MODE_CFG;
            txn          <= '0;
            spi.chip_txd <= rom_cmd;
            cfg_done     <= 1'b0;
            ovr          <= 1'b0;
            init_pend    <= 1'b0;
            state        <= ST_LOAD;
          end else if (start_go) begin
            mode         <= MODE_FRM;
            txn          <= '0;
            spi.chip_txd <= rom_cmd;
            state        <= ST_LOAD;
          end
        end

        // Never raise fs while the engine still reports DONE.
        ST_LOAD: begin
          if (!spi.fd_prd) begin
            spi.fs <= 1'b1;
            state  <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (spi.fd_prd) begin
            spi.fs <= 1'b0;
            state  <= ST_RELS;
            // The result of CONVERT(c) arrives PIPE transactions later.
            if (mode == MODE_FRM && txn >= PIPE_T) begin
              data_vld <= 1'b1;
              ch_idx   <= 6'(txn - PIPE_T);
              data_out <= spi.chip_rxd;
            end
          end
        end

        ST_RELS: begin
          if (!spi.fd_prd) state <= ST_NEXT;
        end

        ST_NEXT: begin
          if (last_txn) begin
            if (mode == MODE_CFG) cfg_done   <= 1'b1;
            else                  frame_done <= 1'b1;
            state <= ST_IDLE;
          end else begin
            txn          <= txn + 7'd1;
            spi.chip_txd <= rom_cmd;
            state        <= ST_LOAD;
          end
        end

        default: begin
          spi.fs <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_seq.sv
// Directed bench for adc_seq: an SPI engine model with 80-cycle latency,
// negedge monitors, and immediate-assertion checks in one linear sequence.
module tb_adc_seq;

  localparam int W_CFG  = 0;
  localparam int W_FD   = 1;
  localparam int W_FS_N = 2;
  localparam int W_FS   = 3;

  logic        clk;
  logic        rst;
  logic        init;
  logic        start;
  logic [31:0] data_out;
  logic        data_vld;
  logic [5:0]  ch_idx;
  logic        frame_done;
  logic        cfg_done;
  logic        busy;
  logic        ovr;

  adc_seq_if sif ();

  adc_seq #(.NUM_CH(32), .PIPE(2), .CAL_DUMMY(9)) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .start      (start),
    .spi        (sif),
    .data_out   (data_out),
    .data_vld   (data_vld),
    .ch_idx     (ch_idx),
    .frame_done (frame_done),
    .cfg_done   (cfg_done),
    .busy       (busy),
    .ovr        (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- SPI engine model ----------------
  int model_cnt;
  int model_base = 0;

  initial begin : spi_model
    bit abort;
    sif.fd_prd   = 1'b0;
    sif.chip_rxd = '0;
    model_cnt    = 0;
    forever begin
      @(negedge clk);
      if (sif.fs === 1'b1 && sif.fd_prd === 1'b0) begin
        abort = 1'b0;
        for (int i = 0; i < 80; i++) begin
          @(negedge clk);
          if (sif.fs !== 1'b1) begin
            abort = 1'b1;
            break;
          end
        end
        if (!abort) begin
          sif.chip_rxd = 32'(model_cnt - model_base);
          sif.fd_prd   = 1'b1;
          model_cnt++;
          for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sif.fs !== 1'b1) break;
          end
          sif.fd_prd = 1'b0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  logic [15:0] txd_log [0:1023];
  logic [5:0]  ch_log  [0:1023];
  logic [31:0] dat_log [0:1023];
  int  fs_cnt = 0, vld_cnt = 0, fd_cnt = 0, viol_cnt = 0, cfg_busy_cnt = 0;
  int  cyc = 0, last_vld_cyc = 0, fd_cyc = 0;
  logic fs_prev = 1'b0;
  bit  watch_cfg = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sif.fs === 1'b1 && fs_prev !== 1'b1) begin
      if (sif.fd_prd === 1'b1) viol_cnt = viol_cnt + 1;
      if (fs_cnt < 1024) txd_log[fs_cnt] = sif.chip_txd;
      fs_cnt = fs_cnt + 1;
    end
    fs_prev = sif.fs;
    if (data_vld === 1'b1) begin
      if (vld_cnt < 1024) begin
        ch_log[vld_cnt]  = ch_idx;
        dat_log[vld_cnt] = data_out;
      end
      vld_cnt      = vld_cnt + 1;
      last_vld_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
    if (watch_cfg && busy === 1'b1 && cfg_done === 1'b1) cfg_busy_cnt = cfg_busy_cnt + 1;
  end

  // ---------------- helpers ----------------
  function automatic bit cond_met(input int sel, input int target);
    case (sel)
      W_CFG:   return cfg_done === 1'b1;
      W_FD:    return fd_cnt >= target;
      W_FS_N:  return fs_cnt >= target;
      default: return sif.fs === 1'b1;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int target, input string tag, input int bound);
    bit ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (cond_met(sel, target)) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic pulse_init();
    @(negedge clk) init = 1'b1;
    @(negedge clk) init = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [15:0] exp_init [0:17];
  initial begin
    exp_init[0] = 16'h8003; exp_init[1] = 16'h8110;
    exp_init[2] = 16'h8200; exp_init[3] = 16'h8344;
    exp_init[4] = 16'h840F; exp_init[5] = 16'h85A5;
    exp_init[6] = 16'h8620; exp_init[7] = 16'h8781;
    exp_init[8] = 16'h5500;
    for (int i = 9; i < 18; i++) exp_init[i] = 16'hE800;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int fb, vb, fdb, gap;

    rst   = 1'b0;
    init  = 1'b0;
    start = 1'b1;
    idle(3);
    check("rst_fs",         32'(sif.fs),     32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_cfg_done",   32'(cfg_done),   32'd0);
    check("rst_ovr",        32'(ovr),        32'd0);
    check("rst_data_vld",   32'(data_vld),   32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // start held high before any init must be ignored
    rst = 1'b1;
    idle(20);
    check("pre_init_fs_cnt", 32'(fs_cnt), 32'd0);
    check("pre_init_busy",   32'(busy),   32'd0);
    check("pre_init_ovr",    32'(ovr),    32'd0);
    start = 1'b0;
    idle(2);

    // configuration sequence
    fb = fs_cnt; vb = vld_cnt; model_base = model_cnt;
    pulse_init();
    check("init_busy", 32'(busy), 32'd1);
    wait_cond(W_CFG, 0, "init_cfg_done_timeout", 5000);
    check("init_txn_count", 32'(fs_cnt - fb), 32'd18);
    for (int i = 0; i < 18; i++)
      check($sformatf("init_cmd[%0d]", i), 32'(txd_log[fb + i]), 32'(exp_init[i]));
    check("init_no_vld",   32'(vld_cnt - vb), 32'd0);
    check("init_idle",     32'(busy),         32'd0);

    // one sampling frame
    fb = fs_cnt; vb = vld_cnt; fdb = fd_cnt; model_base = model_cnt;
    pulse_start();
    wait_cond(W_FD, fdb + 1, "frame_done_timeout", 6000);
    idle(10);
    check("frame_txn_count", 32'(fs_cnt - fb),  32'd34);
    for (int i = 0; i < 34; i++)
      check($sformatf("frame_cmd[%0d]", i), 32'(txd_log[fb + i]),
            (i < 32) ? 32'(i << 8) : 32'h0000_E800);
    check("frame_vld_count", 32'(vld_cnt - vb), 32'd32);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("frame_ch[%0d]", i),   32'(ch_log[vb + i]), 32'(i));
      check($sformatf("frame_data[%0d]", i), dat_log[vb + i],     32'(i + 2));
    end
    check("frame_done_once", 32'(fd_cnt - fdb), 32'd1);
    gap = fd_cyc - last_vld_cyc;
    check("frame_done_after_last", 32'(gap >= 1 && gap <= 2), 32'd1);
    check("frame_idle",    32'(busy),     32'd0);
    check("frame_cfg_ok",  32'(cfg_done), 32'd1);
    check("frame_no_ovr",  32'(ovr),      32'd0);

    // overrun: start at transaction 10
    fb = fs_cnt; vb = vld_cnt; fdb = fd_cnt; model_base = model_cnt;
    pulse_start();
    wait_cond(W_FS_N, fb + 11, "ovr_reach_txn10", 2000);
    pulse_start();
    check("ovr_set", 32'(ovr), 32'd1);
    wait_cond(W_FD, fdb + 1, "ovr_frame_timeout", 6000);
    idle(4);
    check("ovr_frame_len", 32'(fs_cnt - fb),  32'd34);
    check("ovr_vld_count", 32'(vld_cnt - vb), 32'd32);
    check("ovr_held",      32'(ovr),          32'd1);
    fb = fs_cnt; fdb = fd_cnt; model_base = model_cnt;
    pulse_start();
    wait_cond(W_FD, fdb + 1, "ovr_frame2_timeout", 6000);
    idle(4);
    check("ovr_frame2_len", 32'(fs_cnt - fb), 32'd34);
    check("ovr_sticky",     32'(ovr),         32'd1);

    // init arriving mid-frame (transaction 5)
    fb = fs_cnt; vb = vld_cnt; fdb = fd_cnt; model_base = model_cnt;
    pulse_start();
    wait_cond(W_FS_N, fb + 6, "midinit_reach_txn5", 2000);
    pulse_init();
    wait_cond(W_FD, fdb + 1, "midinit_frame_timeout", 6000);
    check("midinit_frame_len", 32'(fs_cnt - fb),  32'd34);
    check("midinit_vld_count", 32'(vld_cnt - vb), 32'd32);
    fb = fs_cnt;
    watch_cfg = 1'b1;
    wait_cond(W_CFG, 0, "midinit_cfg_timeout", 5000);
    watch_cfg = 1'b0;
    check("midinit_init_len",  32'(fs_cnt - fb),       32'd18);
    check("midinit_first_cmd", 32'(txd_log[fb]),       32'h0000_8003);
    check("midinit_cal_cmd",   32'(txd_log[fb + 8]),   32'h0000_5500);
    check("midinit_last_cmd",  32'(txd_log[fb + 17]),  32'h0000_E800);
    check("midinit_cfg_low",   32'(cfg_busy_cnt),      32'd0);
    check("midinit_ovr_clear", 32'(ovr),               32'd0);

    // asynchronous reset during a transaction
    pulse_start();
    wait_cond(W_FS, 0, "rstmid_fs_rise", 200);
    idle(20);
    pulse_start();
    check("rstmid_ovr_pre", 32'(ovr), 32'd1);
    idle(5);
    #2 rst = 1'b0;
    #1;
    check("rstmid_fs",         32'(sif.fs),     32'd0);
    check("rstmid_busy",       32'(busy),       32'd0);
    check("rstmid_ovr",        32'(ovr),        32'd0);
    check("rstmid_cfg_done",   32'(cfg_done),   32'd0);
    check("rstmid_txd",        32'(sif.chip_txd), 32'd0);
    check("rstmid_data_out",   data_out,        32'd0);
    check("rstmid_ch_idx",     32'(ch_idx),     32'd0);
    check("rstmid_vld",        32'(data_vld),   32'd0);
    check("rstmid_frame_done", 32'(frame_done), 32'd0);
    idle(3);
    rst = 1'b1;
    fb = fs_cnt;
    idle(30);
    pulse_start();
    idle(50);
    check("rstmid_no_fs", 32'(fs_cnt - fb), 32'd0);
    check("rstmid_idle",  32'(busy),        32'd0);
    check("fs_vs_fd_prd", 32'(viol_cnt),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
